// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer among
// N_REQ byte producers. One byte is accepted per frame over valid/ready; the
// byte and grant index are held from LAUNCH through GAP.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to build a BUSY watchdog
// that aborts a frame (pulsing o_Timeout) when i_Tx_Done never arrives within
// TIMEOUT_CYCLES cycles. Without it o_Timeout is tied low and BUSY waits forever.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                         i_Clock,
  input  logic                         i_reset,
  input  logic [N_REQ-1:0]             i_Req_Valid,
  input  logic [N_REQ*DATA_BITS-1:0]   i_Req_Byte,
  output logic [N_REQ-1:0]             o_Req_Ready,
  output logic                         o_Tx_Start,
  output logic [DATA_BITS-1:0]         o_Tx_Byte,
  input  logic                         i_Tx_Done,
  output logic [$clog2(N_REQ)-1:0]     o_Grant_Id,
  output logic                         o_Busy,
  output logic                         o_Timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;

  logic                 win_found_s;
  logic [IDW-1:0]       win_idx_s;
  logic                 handshake_s;
  logic [N_REQ-1:0]     win_onehot_s;
  logic [DATA_BITS-1:0] win_byte_s;
  logic                 tc_hit_s;

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      int cand;
      cand = (int'(last_q) + off) % N_REQ;
      if (!win_found_s && i_Req_Valid[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign handshake_s  = (state_q == ST_IDLE) && win_found_s && !i_reset;
  assign win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign win_byte_s   = i_Req_Byte[int'(win_idx_s)*DATA_BITS +: DATA_BITS];

  // Ready is combinational so the winner's transfer completes in the IDLE cycle.
  always_comb begin
    o_Req_Ready = '0;
    if (handshake_s) begin
      o_Req_Ready = win_onehot_s;
    end else begin
      o_Req_Ready = '0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal count only aborts when done is absent; done wins a tie.
  assign tc_hit_s  = (state_q == ST_BUSY) && (cnt_q == CNT_TC) && !i_Tx_Done;
  assign o_Timeout = tc_hit_s && !i_reset;

  // Watchdog counter: cleared in LAUNCH, counts BUSY cycles, parks at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if ((state_q == ST_BUSY) && (cnt_q != CNT_TC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic cfg_unused_s;

  assign cfg_unused_s = (TIMEOUT_CYCLES >= 2);
  assign tc_hit_s     = 1'b0;
  assign o_Timeout    = 1'b0;
`endif

  // Next-state and registered-output logic for the launch/busy/gap sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          state_d = ST_LAUNCH;
          last_d  = win_idx_s;
          grant_d = win_idx_s;
          byte_d  = win_byte_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_Tx_Done) begin
          state_d = ST_GAP;
        end else if (tc_hit_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_GAP: begin
        // Covers the transmitter's cleanup cycle before the next start.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    start_d = (state_d == ST_LAUNCH);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      byte_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Tx_Start = start_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Grant_Id = grant_q;
  assign o_Busy     = busy_q;

endmodule
